// File: rtl/bsg_reset_sequencer.sv
// Synchronizes board reset release, stretches it, then releases staged active-high resets.
// Define BSG_RESET_SEQ_ORDERED_ASSERT_EN to assert stages in reverse order on a software reset.
module bsg_reset_sequencer #(
  parameter int num_stages_p        = 4,
  parameter int sync_stages_p       = 2,
  parameter int lg_stretch_cycles_p = 4,
  parameter int lg_gap_cycles_p     = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    sw_reset_v_i,
  output logic                    sw_reset_ready_o,
  output logic [num_stages_p-1:0] reset_o,
  output logic                    all_released_o,
  output logic                    busy_o
);

  localparam int idx_w_lp   = (num_stages_p > 1) ? $clog2(num_stages_p) : 1;
  localparam int chain_w_lp = sync_stages_p - 1;

  localparam logic [2:0] SYNC    = 3'd0;
  localparam logic [2:0] STRETCH = 3'd1;
  localparam logic [2:0] RELEASE = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
`ifdef BSG_RESET_SEQ_ORDERED_ASSERT_EN
  localparam logic [2:0] ASSERT  = 3'd4;
`endif

  localparam logic [num_stages_p-1:0]        one_lp         = num_stages_p'(1);
  localparam logic [chain_w_lp-1:0]          chain_one_lp   = chain_w_lp'(1);
  localparam logic [idx_w_lp-1:0]            idx_one_lp     = idx_w_lp'(1);
  localparam logic [idx_w_lp-1:0]            last_idx_lp    = idx_w_lp'(num_stages_p - 1);
  localparam logic [lg_stretch_cycles_p-1:0] stretch_one_lp = lg_stretch_cycles_p'(1);
  localparam logic [lg_gap_cycles_p-1:0]     gap_one_lp     = lg_gap_cycles_p'(1);

  logic [chain_w_lp-1:0]          r_sync;
  logic [2:0]                     r_state;
  logic [lg_stretch_cycles_p-1:0] r_stretch_cnt;
  logic [lg_gap_cycles_p-1:0]     r_gap_cnt;
  logic [idx_w_lp-1:0]            r_idx;
  logic [num_stages_p-1:0]        r_reset;
  logic                           r_all_released;
  logic                           r_ready;
  logic                           r_busy;

  logic                           w_sync_out;
  logic                           w_stretch_done;
  logic                           w_gap_done;
  logic [idx_w_lp-1:0]            w_idx_inc;
`ifdef BSG_RESET_SEQ_ORDERED_ASSERT_EN
  logic [idx_w_lp-1:0]            w_idx_dec;
  assign w_idx_dec = r_idx - idx_one_lp;
`endif

  assign w_sync_out     = r_sync[chain_w_lp-1];
  assign w_stretch_done = &r_stretch_cnt;
  assign w_gap_done     = &r_gap_cnt;
  assign w_idx_inc      = r_idx + idx_one_lp;

  // Deassertion synchronizer; the SYNC-state test on r_state is its final stage.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= (r_sync << 1) | chain_one_lp;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state        <= SYNC;
      r_stretch_cnt  <= '0;
      r_gap_cnt      <= '0;
      r_idx          <= '0;
      r_reset        <= '1;
      r_all_released <= 1'b0;
      r_ready        <= 1'b0;
      r_busy         <= 1'b1;
    end else begin
      case (r_state)
        SYNC: begin
          if (w_sync_out) begin
            r_state       <= STRETCH;
            r_stretch_cnt <= '0;
          end else begin
            r_state <= SYNC;
          end
        end
        STRETCH: begin
          if (w_stretch_done) begin
            r_stretch_cnt <= '0;
            r_gap_cnt     <= '0;
            r_idx         <= '0;
            r_reset       <= r_reset & ~one_lp;
            if (num_stages_p == 1) begin
              r_state        <= DONE;
              r_all_released <= 1'b1;
              r_ready        <= 1'b1;
              r_busy         <= 1'b0;
            end else begin
              r_state <= RELEASE;
            end
          end else begin
            r_stretch_cnt <= r_stretch_cnt + stretch_one_lp;
          end
        end
        RELEASE: begin
          if (w_gap_done) begin
            r_gap_cnt <= '0;
            r_idx     <= w_idx_inc;
            r_reset   <= r_reset & ~(one_lp << w_idx_inc);
            if (w_idx_inc == last_idx_lp) begin
              r_state        <= DONE;
              r_all_released <= 1'b1;
              r_ready        <= 1'b1;
              r_busy         <= 1'b0;
            end else begin
              r_state <= RELEASE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + gap_one_lp;
          end
        end
        DONE: begin
          if (sw_reset_v_i && r_ready) begin
            r_stretch_cnt  <= '0;
            r_gap_cnt      <= '0;
            r_all_released <= 1'b0;
            r_ready        <= 1'b0;
            r_busy         <= 1'b1;
`ifdef BSG_RESET_SEQ_ORDERED_ASSERT_EN
            if (num_stages_p == 1) begin
              r_state <= STRETCH;
              r_idx   <= '0;
              r_reset <= '1;
            end else begin
              r_state <= ASSERT;
              r_idx   <= last_idx_lp;
              r_reset <= r_reset | (one_lp << last_idx_lp);
            end
`else
            r_state <= STRETCH;
            r_idx   <= '0;
            r_reset <= '1;
`endif
          end else begin
            r_state <= DONE;
          end
        end
`ifdef BSG_RESET_SEQ_ORDERED_ASSERT_EN
        // Walk assertion down from the top stage, then stretch once stage 0 is set.
        ASSERT: begin
          if (w_gap_done) begin
            r_gap_cnt <= '0;
            r_idx     <= w_idx_dec;
            r_reset   <= r_reset | (one_lp << w_idx_dec);
            if (w_idx_dec == '0) begin
              r_state       <= STRETCH;
              r_stretch_cnt <= '0;
            end else begin
              r_state <= ASSERT;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + gap_one_lp;
          end
        end
`endif
        default: begin
          r_state        <= SYNC;
          r_stretch_cnt  <= '0;
          r_gap_cnt      <= '0;
          r_idx          <= '0;
          r_reset        <= '1;
          r_all_released <= 1'b0;
          r_ready        <= 1'b0;
          r_busy         <= 1'b1;
        end
      endcase
    end
  end

  assign reset_o          = r_reset;
  assign all_released_o   = r_all_released;
  assign sw_reset_ready_o = r_ready;
  assign busy_o           = r_busy;

endmodule
